// File: rtl/inst_decode_stage.sv
// RISC-V decode stage: main + skid buffered valid/ready, fields/immediate decoded from the main register.
// Optional perf counters (cnt_dec, cnt_ill) are enabled by defining DECODE_PERF_EN.
module inst_decode_stage #(
  parameter int XLEN  = 32,
  parameter int PC_W  = 32,
  parameter int CNT_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_inst,
  input  logic [PC_W-1:0]   in_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PC_W-1:0]   out_pc,
  output logic [6:0]        opcode,
  output logic [4:0]        rd,
  output logic [2:0]        fn3,
  output logic [4:0]        rs1,
  output logic [4:0]        rs2,
  output logic [6:0]        fn7,
  output logic [XLEN-1:0]   imm,
  output logic [2:0]        fmt,
  output logic              illegal
`ifdef DECODE_PERF_EN
  ,
  output logic [CNT_W-1:0]  cnt_dec,
  output logic [CNT_W-1:0]  cnt_ill
`endif
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [6:0] OP_R = 7'b0110011, OP_R32 = 7'b0111011, OP_IMM = 7'b0010011,
                         OP_LOAD = 7'b0000011, OP_JALR = 7'b1100111, OP_SYS = 7'b1110011,
                         OP_FENCE = 7'b0001111, OP_IMM32 = 7'b0011011, OP_STORE = 7'b0100011,
                         OP_BR = 7'b1100011, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_JAL = 7'b1101111;
  localparam logic [2:0] F_R = 3'd0, F_I = 3'd1, F_S = 3'd2, F_B = 3'd3,
                         F_U = 3'd4, F_J = 3'd5, F_ILL = 3'd7;

  if (!(XLEN == 32 || XLEN == 64) || PC_W < 1 || CNT_W < 1) begin : g_param_err
    $error("inst_decode_stage: unsupported parameter set");
  end

  logic              main_v_q, main_v_d, skid_v_q, skid_v_d, in_ready_q, in_ready_d;
  logic [31:0]       main_inst_q, main_inst_d, skid_inst_q, skid_inst_d;
  logic [PC_W-1:0]   main_pc_q, main_pc_d, skid_pc_q, skid_pc_d;
  logic              out_hs, in_hs;

  assign out_hs = main_v_q && out_ready;
  assign in_hs  = in_valid && in_ready_q;

  // Skid only ever fills while main is stalled; it refills main on the next drain.
  always_comb begin
    main_v_d    = main_v_q;
    main_inst_d = main_inst_q;
    main_pc_d   = main_pc_q;
    skid_v_d    = skid_v_q;
    skid_inst_d = skid_inst_q;
    skid_pc_d   = skid_pc_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (skid_v_q) begin
      if (out_hs) begin
        main_inst_d = skid_inst_q;
        main_pc_d   = skid_pc_q;
        skid_v_d    = 1'b0;
      end
    end else if (in_hs) begin
      if (!main_v_q || out_ready) begin
        main_v_d    = 1'b1;
        main_inst_d = in_inst;
        main_pc_d   = in_pc;
      end else begin
        skid_v_d    = 1'b1;
        skid_inst_d = in_inst;
        skid_pc_d   = in_pc;
      end
    end else if (out_hs) begin
      main_v_d = 1'b0;
    end
    in_ready_d = !skid_v_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_v_q    <= 1'b0;
      main_inst_q <= NOP;
      main_pc_q   <= '0;
      skid_v_q    <= 1'b0;
      skid_inst_q <= NOP;
      skid_pc_q   <= '0;
      in_ready_q  <= 1'b1;
    end else begin
      main_v_q    <= main_v_d;
      main_inst_q <= main_inst_d;
      main_pc_q   <= main_pc_d;
      skid_v_q    <= skid_v_d;
      skid_inst_q <= skid_inst_d;
      skid_pc_q   <= skid_pc_d;
      in_ready_q  <= in_ready_d;
    end
  end

  logic [31:0] ins, imm32;
  logic [2:0]  fmt_c;

  // Every listed opcode ends in 2'b11, so an opcode match also covers the inst[1:0] check.
  always_comb begin
    ins   = main_inst_q;
    fmt_c = F_ILL;
    imm32 = '0;
    case (ins[6:0])
      OP_R:   fmt_c = F_R;
      OP_R32: if (XLEN == 64) fmt_c = F_R;
      OP_IMM, OP_LOAD, OP_JALR, OP_SYS, OP_FENCE: begin
        fmt_c = F_I;
        imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      OP_IMM32: if (XLEN == 64) begin
        fmt_c = F_I;
        imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      OP_STORE: begin
        fmt_c = F_S;
        imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      OP_BR: begin
        fmt_c = F_B;
        imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        fmt_c = F_U;
        imm32 = {ins[31:12], 12'b0};
      end
      OP_JAL: begin
        fmt_c = F_J;
        imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = main_v_q;
  assign out_pc    = main_pc_q;
  assign opcode    = main_inst_q[6:0];
  assign rd        = main_inst_q[11:7];
  assign fn3       = main_inst_q[14:12];
  assign rs1       = main_inst_q[19:15];
  assign rs2       = main_inst_q[24:20];
  assign fn7       = main_inst_q[31:25];
  assign imm       = XLEN'($signed(imm32));
  assign fmt       = fmt_c;
  assign illegal   = (fmt_c == F_ILL);

`ifdef DECODE_PERF_EN
  logic [CNT_W-1:0] cnt_dec_q, cnt_dec_d, cnt_ill_q, cnt_ill_d;

  // Saturating counters; flush does not clear them.
  always_comb begin
    cnt_dec_d = cnt_dec_q;
    cnt_ill_d = cnt_ill_q;
    if (out_hs && cnt_dec_q != '1) cnt_dec_d = cnt_dec_q + 1'b1;
    if (out_hs && illegal && cnt_ill_q != '1) cnt_ill_d = cnt_ill_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_dec_q <= '0;
      cnt_ill_q <= '0;
    end else begin
      cnt_dec_q <= cnt_dec_d;
      cnt_ill_q <= cnt_ill_d;
    end
  end

  assign cnt_dec = cnt_dec_q;
  assign cnt_ill = cnt_ill_q;
`endif
endmodule

// File: tb/tb_inst_decode_stage.sv
// Directed bench for inst_decode_stage: queue-based occupancy model plus ISA-level decode model,
// checked every cycle, with hand-computed literal expectations for the key vectors.
module tb_inst_decode_stage;
  localparam int XLEN = 32, PC_W = 32, CNT_W = 32;

  logic clk = 1'b0;
  logic rst, flush, in_valid, out_ready;
  logic [31:0] in_inst;
  logic [PC_W-1:0] in_pc;
  logic in_ready, out_valid, illegal;
  logic [PC_W-1:0] out_pc;
  logic [6:0] opcode, fn7;
  logic [4:0] rd, rs1, rs2;
  logic [2:0] fn3, fmt;
  logic [XLEN-1:0] imm;
`ifdef DECODE_PERF_EN
  logic [CNT_W-1:0] cnt_dec, cnt_ill;
`endif

  always #5 clk = ~clk;

  inst_decode_stage #(.XLEN(XLEN), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .opcode(opcode), .rd(rd), .fn3(fn3), .rs1(rs1), .rs2(rs2),
    .fn7(fn7), .imm(imm), .fmt(fmt), .illegal(illegal)
`ifdef DECODE_PERF_EN
    , .cnt_dec(cnt_dec), .cnt_ill(cnt_ill)
`endif
  );

  typedef struct {
    logic [31:0]     inst;
    logic [PC_W-1:0] pc;
  } ent_t;

  ent_t        q[$];
  logic [31:0] dlog[$];
  int          n_chk = 0, n_fail = 0;
  bit          acc;
  longint      m_dec, m_ill;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ISA-level decode: format from the opcode table, immediate from arithmetic on the sign-extended word.
  function automatic void exp_dec(input logic [31:0] w, output logic [2:0] f, output logic [63:0] im);
    longint s;
    s  = longint'($signed(w));
    f  = 3'd7;
    im = '0;
    if (w[1:0] == 2'b11) begin
      case (w[6:0])
        7'h33: f = 3'd0;
        7'h3B: if (XLEN == 64) f = 3'd0;
        7'h13, 7'h03, 7'h67, 7'h73, 7'h0F: begin f = 3'd1; im = s >>> 20; end
        7'h1B: if (XLEN == 64) begin f = 3'd1; im = s >>> 20; end
        7'h23: begin f = 3'd2; im = ((s >>> 25) << 5) | longint'(w[11:7]); end
        7'h63: begin
          f  = 3'd3;
          im = ((s >>> 31) << 12) | (longint'(w[7]) << 11) | (longint'(w[30:25]) << 5)
             | (longint'(w[11:8]) << 1);
        end
        7'h37, 7'h17: begin f = 3'd4; im = s & 64'hFFFF_FFFF_FFFF_F000; end
        7'h6F: begin
          f  = 3'd5;
          im = ((s >>> 31) << 20) | (longint'(w[19:12]) << 12) | (longint'(w[20]) << 11)
             | (longint'(w[30:21]) << 1);
        end
        default: ;
      endcase
    end
    if (XLEN == 32) im = im & 64'h0000_0000_FFFF_FFFF;
  endfunction

  // Stage behaves as a 2-deep FIFO: accept while fewer than 2 held, present the oldest.
  task automatic model_step();
    bit hs_out, can_in;
    acc = 1'b0;
    if (rst) begin
      q.delete();
      m_dec = 0;
      m_ill = 0;
    end else begin
      hs_out = (q.size() > 0) && out_ready;
      can_in = in_valid && (q.size() < 2);
      if (hs_out) begin
        logic [2:0]  f;
        logic [63:0] im;
        exp_dec(q[0].inst, f, im);
        m_dec++;
        if (f == 3'd7) m_ill++;
      end
      if (flush) q.delete();
      else begin
        if (hs_out) begin
          dlog.push_back(q[0].inst);
          void'(q.pop_front());
        end
        if (can_in) begin
          q.push_back('{inst: in_inst, pc: in_pc});
          acc = 1'b1;
        end
      end
    end
  endtask

  task automatic model_check();
    logic [2:0]  f;
    logic [63:0] im;
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    if (q.size() > 0) begin
      exp_dec(q[0].inst, f, im);
      chk("out_pc", out_pc, q[0].pc);
      chk("opcode", opcode, q[0].inst[6:0]);
      chk("rd", rd, q[0].inst[11:7]);
      chk("fn3", fn3, q[0].inst[14:12]);
      chk("rs1", rs1, q[0].inst[19:15]);
      chk("rs2", rs2, q[0].inst[24:20]);
      chk("fn7", fn7, q[0].inst[31:25]);
      chk("imm", imm, im);
      chk("fmt", fmt, f);
      chk("illegal", illegal, f == 3'd7);
    end
`ifdef DECODE_PERF_EN
    chk("cnt_dec", cnt_dec, m_dec);
    chk("cnt_ill", cnt_ill, m_ill);
`endif
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_check();
  endtask

  task automatic send1(input logic [31:0] w, input logic [PC_W-1:0] pc);
    in_valid  = 1'b1;
    in_inst   = w;
    in_pc     = pc;
    out_ready = 1'b1;
    cyc();
    in_valid  = 1'b0;
  endtask

  // Present a word until accepted; out_ready follows ordy on the first try, then 1.
  task automatic push_word(input logic [31:0] w, input logic [PC_W-1:0] pc, input logic ordy);
    int tries;
    in_valid  = 1'b1;
    in_inst   = w;
    in_pc     = pc;
    out_ready = ordy;
    tries     = 0;
    do begin
      cyc();
      out_ready = 1'b1;
      tries++;
    end while (!acc && tries < 10);
    if (!acc) chk("push_accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  logic [31:0] ws[3];
  logic [31:0] mix[12];

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = '0; in_pc = '0;
    cyc();
    cyc();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_opcode", opcode, 7'h13);
    chk("rst_rd", rd, 0);
    chk("rst_imm", imm, 0);
    chk("rst_fmt", fmt, 1);
    chk("rst_illegal", illegal, 0);
    chk("rst_pc", out_pc, 0);
    rst = 1'b0;

    send1(32'hFFF0_0093, 32'h100);
    chk("t1_valid", out_valid, 1);
    chk("t1_opcode", opcode, 7'h13);
    chk("t1_rd", rd, 1);
    chk("t1_fmt", fmt, 1);
    chk("t1_imm", imm, 64'hFFFF_FFFF);
    chk("t1_pc", out_pc, 32'h100);

    send1(32'h0020_A423, 32'h104);
    chk("t2s_fmt", fmt, 2);
    chk("t2s_rs1", rs1, 1);
    chk("t2s_rs2", rs2, 2);
    chk("t2s_fn3", fn3, 2);
    chk("t2s_imm", imm, 8);
    send1(32'hFE00_0EE3, 32'h108);
    chk("t2b_fmt", fmt, 3);
    chk("t2b_imm", imm, 64'hFFFF_FFFC);

    send1(32'h1234_52B7, 32'h10C);
    chk("t3_fmt", fmt, 4);
    chk("t3_rd", rd, 5);
    chk("t3_imm", imm, 64'h1234_5000);

    send1(32'h0000_0000, 32'h110);
    chk("t6_illegal", illegal, 1);
    chk("t6_fmt", fmt, 7);
    chk("t6_imm", imm, 0);
    cyc();
    chk("t6_drained", out_valid, 0);
`ifdef DECODE_PERF_EN
    chk("t6_cnt_ill", cnt_ill, 1);
    chk("t6_cnt_dec", cnt_dec, 5);
`endif

    // Three-word stream against a stalled consumer, then release.
    begin
      int idx, base;
      ws[0] = 32'h0050_0113; ws[1] = 32'h4020_8033; ws[2] = 32'h0000_006F;
      base = dlog.size();
      idx = 0;
      out_ready = 1'b0; in_valid = 1'b1; in_inst = ws[0]; in_pc = 32'h200;
      repeat (3) begin
        cyc();
        if (acc) begin
          idx++;
          if (idx < 3) begin in_inst = ws[idx]; in_pc = 32'h200 + 32'(4 * idx); end
          else in_valid = 1'b0;
        end
      end
      chk("t4_accepted", idx, 2);
      chk("t4_in_ready", in_ready, 0);
      chk("t4_out_valid", out_valid, 1);
      out_ready = 1'b1;
      for (int c = 0; c < 20 && !(idx == 3 && q.size() == 0); c++) begin
        cyc();
        if (acc) begin
          idx++;
          if (idx < 3) begin in_inst = ws[idx]; in_pc = 32'h200 + 32'(4 * idx); end
          else in_valid = 1'b0;
        end
      end
      chk("t4_done", (idx == 3) && (q.size() == 0), 1);
      chk("t4_count", dlog.size() - base, 3);
      for (int k = 0; k < 3; k++)
        if (base + k < dlog.size()) chk($sformatf("t4_order%0d", k), dlog[base + k], ws[k]);
    end

    // Flush with a full skid and a word presented in the same cycle.
    out_ready = 1'b0;
    in_valid = 1'b1; in_inst = 32'h0010_0093; in_pc = 32'h300;
    cyc();
    in_inst = 32'h0020_0113; in_pc = 32'h304;
    cyc();
    chk("t5_full", in_ready, 0);
    flush = 1'b1; in_inst = 32'h0030_0193; in_pc = 32'h308;
    cyc();
    chk("t5_out_valid", out_valid, 0);
    chk("t5_in_ready", in_ready, 1);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();
    chk("t5_no_emit", out_valid, 0);

    // Mixed formats and illegal encodings with an irregular consumer.
    mix[0] = 32'h4020_8033; mix[1] = 32'h0041_2083; mix[2]  = 32'h0000_80E7;
    mix[3] = 32'h0000_0073; mix[4] = 32'h0000_000F; mix[5]  = 32'h0000_1517;
    mix[6] = 32'h8000_00EF; mix[7] = 32'h0000_0090; mix[8]  = 32'h0000_003B;
    mix[9] = 32'h0000_001B; mix[10] = 32'h7FF0_0013; mix[11] = 32'h8000_0FE3;
    for (int i = 0; i < 12; i++) push_word(mix[i], 32'h400 + 32'(4 * i), 1'(i % 3 != 0));
    out_ready = 1'b0;
    repeat (2) cyc();
    out_ready = 1'b1;
    repeat (4) cyc();
    chk("mix_drained", out_valid, 0);

    // Reset while holding two words restores the NOP view.
    out_ready = 1'b0;
    push_word(32'h0000_0537, 32'h500, 1'b0);
    out_ready = 1'b0;
    push_word(32'h0000_05B7, 32'h504, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst2_out_valid", out_valid, 0);
    chk("rst2_in_ready", in_ready, 1);
    chk("rst2_opcode", opcode, 7'h13);
    chk("rst2_fmt", fmt, 1);
`ifdef DECODE_PERF_EN
    chk("rst2_cnt_dec", cnt_dec, 0);
`endif
    cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
